// File: rtl/aes_key_sched.sv
// aes_key_sched: on-the-fly AES-128 key schedule.
//
// Captures a 128-bit cipher key on `start` and presents round keys 0..10 one at a time.
// Each round key is held until the consumer pulses `next`. The following key is then
// produced in two hidden cycles: SUB registers SubWord(RotWord(w3)) and EXPAND computes
// the new round key. Only the current round key is stored.
//
// Ports:
//   clk       in   system clock, rising edge
//   nreset    in   synchronous active-low reset
//   start     in   capture `key` and restart at round 0 (priority over everything else)
//   key       in   128-bit cipher key, key[127:96] = w0, key[127:120] = byte 0
//   next      in   request the following round key (acted on only while `valid`)
//   roundkey  out  current round key, same byte order as `key`
//   round     out  index of `roundkey`, 0..10
//   valid     out  `roundkey` / `round` are valid
//   last      out  valid && round == 10
//   busy      out  schedule in progress, from `start` until round 10 is consumed

`timescale 1ns/1ps

module aes_key_sched (
  input  logic         clk,
  input  logic         nreset,
  input  logic         start,
  input  logic [127:0] key,
  input  logic         next,
  output logic [127:0] roundkey,
  output logic [3:0]   round,
  output logic         valid,
  output logic         last,
  output logic         busy
);

  typedef enum logic [1:0] {StIdle, StHold, StSub, StExpand} state_e;

  localparam logic [7:0] Sbox [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  state_e       state_q;
  logic [127:0] rk_q;
  logic [3:0]   round_q;
  logic [7:0]   rcon_q;    // Rcon for the round being produced next
  logic [31:0]  sub_q;     // SubWord(RotWord(w3)) captured in SUB
  logic         valid_q;
  logic         busy_q;
  logic         next_q;    // previous `next`, so a held request is honoured only once

  logic         next_req;
  logic [31:0]  w0_d, w1_d, w2_d, w3_d;
  logic [7:0]   rcon_d;

  // Only a fresh request counts; keeping `next` high must not consume several rounds.
  assign next_req = next & ~next_q;

  always_comb begin
    w0_d   = rk_q[127:96] ^ sub_q ^ {rcon_q, 24'h0};
    w1_d   = rk_q[95:64] ^ w0_d;
    w2_d   = rk_q[63:32] ^ w1_d;
    w3_d   = rk_q[31:0] ^ w2_d;
    rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q <= StIdle;
      rk_q    <= '0;
      round_q <= '0;
      rcon_q  <= '0;
      sub_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      next_q  <= 1'b0;
    end else begin
      next_q <= next;
      if (start) begin
        // Any in-flight expansion is simply abandoned.
        rk_q    <= key;
        round_q <= '0;
        rcon_q  <= 8'h01;
        valid_q <= 1'b1;
        busy_q  <= 1'b1;
        state_q <= StHold;
      end else begin
        case (state_q)
          StIdle: begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
          StHold: begin
            if (next_req) begin
              valid_q <= 1'b0;
              if (round_q == 4'd10) begin
                busy_q  <= 1'b0;
                state_q <= StIdle;
              end else begin
                state_q <= StSub;
              end
            end
          end
          StSub: begin
            // RotWord(w3) = {b13, b14, b15, b12}; the table read is registered here.
            sub_q   <= {Sbox[rk_q[23:16]], Sbox[rk_q[15:8]], Sbox[rk_q[7:0]], Sbox[rk_q[31:24]]};
            state_q <= StExpand;
          end
          StExpand: begin
            rk_q    <= {w0_d, w1_d, w2_d, w3_d};
            round_q <= round_q + 4'd1;
            rcon_q  <= rcon_d;
            valid_q <= 1'b1;
            state_q <= StHold;
          end
          default: begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign roundkey = rk_q;
  assign round    = round_q;
  assign valid    = valid_q;
  assign busy     = busy_q;
  assign last     = valid_q & (round_q == 4'd10);

endmodule

// File: doc/aes_key_sched.md
# aes_key_sched

On-the-fly AES-128 key schedule for the FPGA AES system. It captures the 128-bit cipher key once the SPI shift-in completes and produces round keys 0 through 10 one at a time, on demand. The consumer is the cipher core's AddRoundKey stage, which requests each round key with a `next` handshake. Only the current round key is stored; the 11-word schedule is never buffered.

## Interface
Parameters: none (AES-128 only).
- `clk`  in  1  system clock; all state changes on the rising edge
- `nreset`  in  1  synchronous, active-low reset
- `start`  in  1  one-cycle pulse; captures `key` and restarts the schedule at round 0
- `key`  in  128  cipher key; `key[127:96]` is w0 and `key[127:120]` is byte 0
- `next`  in  1  consumer has used `roundkey` and requests the following round key
- `roundkey`  out  128  current round key, in the same byte order as `key`
- `round`  out  4  index of `roundkey`, 0..10
- `valid`  out  1  `roundkey` and `round` are valid
- `last`  out  1  `valid && round == 10`
- `busy`  out  1  schedule is in progress, from `start` until round 10 is consumed

## Operation
- States: IDLE, HOLD, SUB, EXPAND.
- IDLE: `valid` = 0 and `busy` = 0. When `start` = 1: `roundkey` ← `key`, `round` ← 0, go to HOLD.
- HOLD: `valid` = 1 and `busy` = 1. Outputs are held stable until `next`.
  - `next` with `round` < 10: go to SUB.
  - `next` with `round` == 10: go to IDLE.
- SUB: `valid` = 0. The four S-box lookups of RotWord(w3) are registered here; the S-box has a one-cycle synchronous read. Go to EXPAND.
- EXPAND: `valid` = 0. Compute the next round key:
  - w0' = w0 ^ SubWord(RotWord(w3)) ^ {Rcon, 24'h0}
  - w1' = w1 ^ w0'
  - w2' = w2 ^ w1'
  - w3' = w3 ^ w2'
  - Register the new round key, increment `round`, go to HOLD.
- Rcon is indexed by the new round number: 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36. Rcon comes from a table or from xtime of the previous value; it is stored as 8 bits.
- `start` has priority in every state. When it is asserted mid-schedule, the in-flight expansion is discarded, `key` is recaptured, and the next cycle shows round 0 with `valid` = 1.
- `next` is ignored when `valid` = 0. `start` and `next` asserted in the same cycle: `start` wins.
- `next` in HOLD is honoured only on the cycle it is sampled; holding it high for several cycles does not skip rounds.
- `round` never exceeds 10 and does not wrap.

## Timing
- Reset (`nreset` = 0 at an edge): state IDLE; `roundkey` = 0, `round` = 0, `valid` = 0, `last` = 0, `busy` = 0. Reset applies in any state, including mid-expansion.
- Start latency: `start` sampled at edge k gives `valid` = 1 with round 0 after edge k.
- Next-key latency: `next` sampled at edge k gives `valid` = 0 after edges k and k+1, and `valid` = 1 with round + 1 after edge k+2.
- Full schedule: consuming every key immediately takes 1 + 3×10 + 1 = 32 cycles from `start` to `busy` = 0.
- Data stability: `roundkey` and `round` change only at the edge that sets `valid` = 1, and at reset. They are not modified while `valid` = 0.
- `last` is combinational from registered state and carries no extra latency.

## Test plan
- **FIPS-197 A.1 key:** `start` with key 2B7E151628AED2A6ABF7158809CF4F3C, then `next` on every valid cycle. Required:
  - round 0 = key
  - round 1 = A0FAFE1788542CB123A339392A6C7605
  - round 2 = F2C295F27A96B9435935807A7359F67F
  - round 10 = D014F9A8C9EE2589E13F0CC8B6630CA6 with `last` = 1
  - after the final `next`: `busy` = 0 and `valid` = 0
- **Appendix C.1 key:** key 000102030405060708090A0B0C0D0E0F. Required: round 10 = 13111D7FE3944A17F307A78B4D2B30C5.
- **Handshake latency and stability:** `next` held high for 5 cycles at round 0. Required:
  - `valid` low for exactly 2 cycles
  - round 1 appears once and is held, with no skip to round 2
  - a random `next` gap of 0 to 20 cycles leaves `roundkey` unchanged during the gap
- **Restart mid-schedule:** run the A.1 key to round 4, then assert `start` with the C.1 key during SUB. Required: the next valid output is round 0 = 000102…0F, and the schedule completes to the C.1 round 10 value.
- **Reset mid-operation:** drive `nreset` = 0 during EXPAND at round 6. Required:
  - all outputs are 0 after that edge
  - `next` pulses during reset or in IDLE produce no output change
  - a fresh `start` runs correctly to completion
- **Ignored `next`:** pulse `next` in IDLE and during SUB. Required: no state change and no round increment.
